// File: rtl/midi_pkg.sv
// Shared MIDI status constants, parser state type and byte classification helpers.
package midi_pkg;

   localparam logic [7:0] ST_SYSEX = 8'hF0;
   localparam logic [7:0] ST_EOX   = 8'hF7;
   localparam logic [7:0] ST_CLOCK = 8'hF8;
   localparam logic [7:0] ST_SENSE = 8'hFE;
   localparam logic [7:0] ST_TUNE  = 8'hF6;

   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

   // Total message length for a status byte; 0 for data bytes and statuses
   // that never form a standalone message (F0, F4, F5, F7).
   function automatic logic [1:0] msg_len_of(input logic [7:0] s);
      logic [1:0] len;
      if (!s[7])             len = 2'd0;
      else if (s >= 8'hF8)   len = 2'd1;
      else if (s < 8'hC0)    len = 2'd3;
      else if (s < 8'hE0)    len = 2'd2;
      else if (s < 8'hF0)    len = 2'd3;
      else begin
         case (s)
            8'hF1, 8'hF3: len = 2'd2;
            8'hF2:        len = 2'd3;
            8'hF6:        len = 2'd1;
            default:      len = 2'd0;
         endcase
      end
      return len;
   endfunction

   function automatic logic is_realtime(input logic [7:0] b);
      return b[7:3] == 5'b11111;
   endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Assembles a UART byte stream into whole MIDI messages plus a SysEx byte stream.
// All outputs are registered one cycle after the final byte; no backpressure, flags pulse for one cycle.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter logic FILTER_CLOCK = 1'b1,
   parameter logic FILTER_SENSE = 1'b1,
   parameter int   ERR_CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_dv,
   input  logic [7:0]           in_data,
   output logic                 msg_valid,
   output logic [7:0]           msg_status,
   output logic [6:0]           msg_data1,
   output logic [6:0]           msg_data2,
   output logic [1:0]           msg_len,
   output logic                 sx_valid,
   output logic [7:0]           sx_data,
   output logic                 sx_abort,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t     state, state_n;
   logic [7:0] rs_status, rs_n;
   logic [6:0] d1, d1_n;
   // Set once a message has completed under the current status, so a new
   // status interrupting running status is not treated as a truncation.
   logic       have_data, have_n;

   logic       mv_n, sv_n, ab_n, er_n;
   logic [7:0] st_n, sd_n;
   logic [6:0] o1_n, o2_n;
   logic [1:0] len_n;
   logic [1:0] cur_len;

   always_comb begin
      state_n = state;
      rs_n    = rs_status;
      d1_n    = d1;
      have_n  = have_data;
      mv_n    = 1'b0;
      sv_n    = 1'b0;
      ab_n    = 1'b0;
      er_n    = 1'b0;
      st_n    = msg_status;
      o1_n    = msg_data1;
      o2_n    = msg_data2;
      len_n   = msg_len;
      sd_n    = sx_data;
      cur_len = msg_len_of(rs_status);

      if (in_dv) begin
         if (is_realtime(in_data)) begin
            if (!((in_data == ST_CLOCK && FILTER_CLOCK) || (in_data == ST_SENSE && FILTER_SENSE))) begin
               mv_n  = 1'b1;
               st_n  = in_data;
               o1_n  = 7'd0;
               o2_n  = 7'd0;
               len_n = 2'd1;
            end
         end else if (!in_data[7]) begin
            unique case (state)
               IDLE: er_n = 1'b1;
               SYSEX: begin
                  sv_n = 1'b1;
                  sd_n = in_data;
               end
               WAIT_D1: begin
                  if (cur_len == 2'd2) begin
                     mv_n  = 1'b1;
                     st_n  = rs_status;
                     o1_n  = in_data[6:0];
                     o2_n  = 7'd0;
                     len_n = 2'd2;
                     if (rs_status >= 8'hF0) begin
                        state_n = IDLE;
                        rs_n    = 8'd0;
                     end else begin
                        have_n = 1'b1;
                     end
                  end else begin
                     d1_n    = in_data[6:0];
                     state_n = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  mv_n  = 1'b1;
                  st_n  = rs_status;
                  o1_n  = d1;
                  o2_n  = in_data[6:0];
                  len_n = 2'd3;
                  if (rs_status >= 8'hF0) begin
                     state_n = IDLE;
                     rs_n    = 8'd0;
                  end else begin
                     state_n = WAIT_D1;
                     have_n  = 1'b1;
                  end
               end
            endcase
         end else begin
            er_n    = (state == WAIT_D2) || (state == WAIT_D1 && !have_data);
            ab_n    = (state == SYSEX) && (in_data != ST_EOX);
            rs_n    = 8'd0;
            have_n  = 1'b0;
            state_n = IDLE;
            if (in_data == ST_EOX) begin
               if (state == SYSEX) begin
                  sv_n = 1'b1;
                  sd_n = in_data;
               end else begin
                  er_n = 1'b1;
               end
            end else if (in_data == ST_SYSEX) begin
               sv_n    = 1'b1;
               sd_n    = in_data;
               state_n = SYSEX;
            end else if (in_data == ST_TUNE) begin
               mv_n  = 1'b1;
               st_n  = in_data;
               o1_n  = 7'd0;
               o2_n  = 7'd0;
               len_n = 2'd1;
            end else if (msg_len_of(in_data) != 2'd0) begin
               rs_n    = in_data;
               state_n = WAIT_D1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rs_status  <= 8'd0;
         d1         <= 7'd0;
         have_data  <= 1'b0;
         msg_valid  <= 1'b0;
         msg_status <= 8'd0;
         msg_data1  <= 7'd0;
         msg_data2  <= 7'd0;
         msg_len    <= 2'd0;
         sx_valid   <= 1'b0;
         sx_data    <= 8'd0;
         sx_abort   <= 1'b0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_n;
         rs_status  <= rs_n;
         d1         <= d1_n;
         have_data  <= have_n;
         msg_valid  <= mv_n;
         msg_status <= st_n;
         msg_data1  <= o1_n;
         msg_data2  <= o2_n;
         msg_len    <= len_n;
         sx_valid   <= sv_n;
         sx_data    <= sd_n;
         sx_abort   <= ab_n;
         err_pulse  <= er_n;
         if (er_n && err_count != '1)
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed table plus randomized bytes against a message-level reference model, two filter configurations.
module tb_midi_msg_parser;

   typedef struct packed {
      logic        mv;
      logic [7:0]  st;
      logic [6:0]  d1;
      logic [6:0]  d2;
      logic [1:0]  len;
      logic        sv;
      logic [7:0]  sd;
      logic        ab;
      logic        er;
      logic [15:0] ec;
   } out_t;

   typedef struct packed {
      logic       sysex;
      logic [7:0] rs;     // 0 means no running status
      logic [1:0] nb;     // data bytes collected for the current message
      logic [6:0] b1;
      logic       fresh;  // status seen, no message completed under it yet
      out_t       o;
   } m_t;

   typedef struct packed {
      logic        r;
      logic        dv;
      logic [7:0]  b;
      logic        mv;
      logic [7:0]  st;
      logic [6:0]  e1;
      logic [6:0]  e2;
      logic [1:0]  len;
      logic        sv;
      logic [7:0]  sd;
      logic        ab;
      logic        er;
      logic [15:0] ec;
   } row_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_dv;
   logic [7:0] in_data;

   logic        mv0, sv0, ab0, er0, mv1, sv1, ab1, er1;
   logic [7:0]  st0, sd0, st1, sd1;
   logic [6:0]  a0, b0, a1, b1;
   logic [1:0]  l0, l1;
   logic [2:0]  ec0;
   logic [15:0] ec1;

   int vec = 0;
   int bad = 0;
   m_t m0, m1;

   midi_msg_parser #(.FILTER_CLOCK(1'b0), .FILTER_SENSE(1'b0), .ERR_CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .in_dv(in_dv), .in_data(in_data),
      .msg_valid(mv0), .msg_status(st0), .msg_data1(a0), .msg_data2(b0), .msg_len(l0),
      .sx_valid(sv0), .sx_data(sd0), .sx_abort(ab0), .err_pulse(er0), .err_count(ec0));

   midi_msg_parser #(.FILTER_CLOCK(1'b1), .FILTER_SENSE(1'b1), .ERR_CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .in_dv(in_dv), .in_data(in_data),
      .msg_valid(mv1), .msg_status(st1), .msg_data1(a1), .msg_data2(b1), .msg_len(l1),
      .sx_valid(sv1), .sx_data(sd1), .sx_abort(ab1), .err_pulse(er1), .err_count(ec1));

   function automatic out_t obs0();
      out_t o;
      o = '{mv0, st0, a0, b0, l0, sv0, sd0, ab0, er0, {13'd0, ec0}};
      return o;
   endfunction

   function automatic out_t obs1();
      out_t o;
      o = '{mv1, st1, a1, b1, l1, sv1, sd1, ab1, er1, ec1};
      return o;
   endfunction

   function automatic int need_of(input logic [7:0] s);
      if ((s >= 8'hC0 && s <= 8'hDF) || s == 8'hF1 || s == 8'hF3) return 1;
      return 2;
   endfunction

   task automatic emit(inout m_t m, input logic [7:0] s, input logic [6:0] x, input logic [6:0] y,
                       input logic [1:0] n);
      m.o.mv = 1'b1; m.o.st = s; m.o.d1 = x; m.o.d2 = y; m.o.len = n;
   endtask

   task automatic mstep(inout m_t m, input logic r, input logic dv, input logic [7:0] b,
                        input logic fc, input logic fs, input int cmax);
      logic trunc;
      m.o.mv = 1'b0; m.o.sv = 1'b0; m.o.ab = 1'b0; m.o.er = 1'b0;
      if (r) begin
         m = '0;
         return;
      end
      if (!dv) return;
      if (b >= 8'hF8) begin
         if (!((b == 8'hF8 && fc) || (b == 8'hFE && fs))) emit(m, b, 7'd0, 7'd0, 2'd1);
         return;
      end
      if (b < 8'h80) begin
         if (m.sysex) begin
            m.o.sv = 1'b1; m.o.sd = b;
         end else if (m.rs == 8'd0) begin
            m.o.er = 1'b1;
         end else if (need_of(m.rs) == 2 && m.nb == 2'd0) begin
            m.b1 = b[6:0]; m.nb = 2'd1;
         end else begin
            if (need_of(m.rs) == 1) emit(m, m.rs, b[6:0], 7'd0, 2'd2);
            else                    emit(m, m.rs, m.b1, b[6:0], 2'd3);
            m.nb = 2'd0; m.fresh = 1'b0;
            if (m.rs >= 8'hF0) m.rs = 8'd0;
         end
      end else begin
         trunc = (m.rs != 8'd0) && (m.nb != 2'd0 || m.fresh);
         m.o.ab = m.sysex && (b != 8'hF7);
         m.o.er = trunc;
         m.nb = 2'd0; m.fresh = 1'b1; m.rs = 8'd0;
         if (b == 8'hF7) begin
            if (m.sysex) begin m.o.sv = 1'b1; m.o.sd = b; end
            else m.o.er = 1'b1;
            m.sysex = 1'b0;
         end else if (b == 8'hF0) begin
            m.sysex = 1'b1; m.o.sv = 1'b1; m.o.sd = b;
         end else begin
            m.sysex = 1'b0;
            if (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) m.rs = b;
            else if (b == 8'hF6) emit(m, b, 7'd0, 7'd0, 2'd1);
         end
      end
      if (m.o.er && int'(m.o.ec) != cmax) m.o.ec = m.o.ec + 16'd1;
   endtask

   task automatic cmp(input string nm, input out_t got, input out_t want);
      vec++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got mv=%b st=%h d1=%h d2=%h len=%0d sv=%b sd=%h ab=%b er=%b ec=%0d, want mv=%b st=%h d1=%h d2=%h len=%0d sv=%b sd=%h ab=%b er=%b ec=%0d",
                  nm, got.mv, got.st, got.d1, got.d2, got.len, got.sv, got.sd, got.ab, got.er, got.ec,
                  want.mv, want.st, want.d1, want.d2, want.len, want.sv, want.sd, want.ab, want.er, want.ec);
      end
   endtask

   task automatic tick(input logic r, input logic dv, input logic [7:0] b);
      @(negedge clk);
      rst = r; in_dv = dv; in_data = b;
      mstep(m0, r, dv, b, 1'b0, 1'b0, 7);
      mstep(m1, r, dv, b, 1'b1, 1'b1, 65535);
      @(posedge clk);
      #1;
      cmp("model_nofilter", obs0(), m0.o);
      cmp("model_filter", obs1(), m1.o);
   endtask

   function automatic row_t mk(input logic r, input logic [7:0] b, input logic mv, input logic [7:0] st,
                               input logic [6:0] e1, input logic [6:0] e2, input logic [1:0] len,
                               input logic sv, input logic [7:0] sd, input logic ab, input logic er,
                               input int ec);
      row_t t;
      t = '{r, !r, b, mv, st, e1, e2, len, sv, sd, ab, er, 16'(ec)};
      return t;
   endfunction

   function automatic row_t nr(input logic [7:0] b, input int ec);
      return mk(1'b0, b, 1'b0, 8'h0, 7'h0, 7'h0, 2'd0, 1'b0, 8'h0, 1'b0, 1'b0, ec);
   endfunction
   function automatic row_t mr(input logic [7:0] b, input logic [7:0] st, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [1:0] len, input int ec);
      return mk(1'b0, b, 1'b1, st, e1, e2, len, 1'b0, 8'h0, 1'b0, 1'b0, ec);
   endfunction
   function automatic row_t sr(input logic [7:0] b, input int ec);
      return mk(1'b0, b, 1'b0, 8'h0, 7'h0, 7'h0, 2'd0, 1'b1, b, 1'b0, 1'b0, ec);
   endfunction
   function automatic row_t er(input logic [7:0] b, input int ec);
      return mk(1'b0, b, 1'b0, 8'h0, 7'h0, 7'h0, 2'd0, 1'b0, 8'h0, 1'b0, 1'b1, ec);
   endfunction

   initial begin
      row_t tbl[$];
      out_t g;
      logic [7:0] rb;
      logic rr, rdv;

      tbl.push_back(nr(8'h90, 0));  tbl.push_back(nr(8'h3C, 0));
      tbl.push_back(mr(8'h40, 8'h90, 7'h3C, 7'h40, 2'd3, 0));
      tbl.push_back(nr(8'h3E, 0));
      tbl.push_back(mr(8'h50, 8'h90, 7'h3E, 7'h50, 2'd3, 0));
      tbl.push_back(nr(8'hC5, 0));
      tbl.push_back(mr(8'h07, 8'hC5, 7'h07, 7'h00, 2'd2, 0));
      tbl.push_back(mr(8'h08, 8'hC5, 7'h08, 7'h00, 2'd2, 0));
      tbl.push_back(mr(8'hF8, 8'hF8, 7'h00, 7'h00, 2'd1, 0));
      tbl.push_back(nr(8'h90, 0));  tbl.push_back(nr(8'h3C, 0));
      tbl.push_back(mr(8'hFA, 8'hFA, 7'h00, 7'h00, 2'd1, 0));
      tbl.push_back(mr(8'h40, 8'h90, 7'h3C, 7'h40, 2'd3, 0));
      tbl.push_back(sr(8'hF0, 0));  tbl.push_back(sr(8'h7E, 0));  tbl.push_back(sr(8'h01, 0));
      tbl.push_back(mr(8'hF8, 8'hF8, 7'h00, 7'h00, 2'd1, 0));
      tbl.push_back(sr(8'hF7, 0));  tbl.push_back(sr(8'hF0, 0));  tbl.push_back(sr(8'h01, 0));
      tbl.push_back(mk(1'b0, 8'h90, 1'b0, 8'h0, 7'h0, 7'h0, 2'd0, 1'b0, 8'h0, 1'b1, 1'b0, 0));
      tbl.push_back(nr(8'h3C, 0));
      tbl.push_back(mr(8'h40, 8'h90, 7'h3C, 7'h40, 2'd3, 0));
      tbl.push_back(mk(1'b1, 8'h00, 1'b0, 8'h0, 7'h0, 7'h0, 2'd0, 1'b0, 8'h0, 1'b0, 1'b0, 0));
      tbl.push_back(er(8'h40, 1));
      tbl.push_back(nr(8'h90, 1));  tbl.push_back(nr(8'h3C, 1));
      tbl.push_back(er(8'hB0, 2));
      tbl.push_back(nr(8'h07, 2));
      tbl.push_back(mr(8'h7F, 8'hB0, 7'h07, 7'h7F, 2'd3, 2));
      tbl.push_back(nr(8'h90, 2));
      tbl.push_back(mk(1'b1, 8'h00, 1'b0, 8'h0, 7'h0, 7'h0, 2'd0, 1'b0, 8'h0, 1'b0, 1'b0, 0));
      for (int k = 1; k <= 7; k++) tbl.push_back(er(8'h3C, k));
      tbl.push_back(er(8'h3C, 7));
      tbl.push_back(mr(8'hFD, 8'hFD, 7'h00, 7'h00, 2'd1, 7));
      tbl.push_back(mr(8'hF6, 8'hF6, 7'h00, 7'h00, 2'd1, 7));
      tbl.push_back(nr(8'hF4, 7));

      rst = 1'b1; in_dv = 1'b0; in_data = 8'h00;
      m0 = '0; m1 = '0;
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, 8'h90);
      cmp("reset_state", obs0(), out_t'(0));

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].r, tbl[i].dv, tbl[i].b);
         g = obs0();
         vec++;
         if (g.mv !== tbl[i].mv || g.sv !== tbl[i].sv || g.ab !== tbl[i].ab || g.er !== tbl[i].er ||
             g.ec !== tbl[i].ec ||
             (tbl[i].mv && (g.st !== tbl[i].st || g.d1 !== tbl[i].e1 || g.d2 !== tbl[i].e2 || g.len !== tbl[i].len)) ||
             (tbl[i].sv && g.sd !== tbl[i].sd)) begin
            bad++;
            $display("FAIL table_row_%0d byte %h: got mv=%b st=%h d1=%h d2=%h len=%0d sv=%b sd=%h ab=%b er=%b ec=%0d, want mv=%b st=%h d1=%h d2=%h len=%0d sv=%b sd=%h ab=%b er=%b ec=%0d",
                     i, tbl[i].b, g.mv, g.st, g.d1, g.d2, g.len, g.sv, g.sd, g.ab, g.er, g.ec,
                     tbl[i].mv, tbl[i].st, tbl[i].e1, tbl[i].e2, tbl[i].len, tbl[i].sv, tbl[i].sd,
                     tbl[i].ab, tbl[i].er, tbl[i].ec);
         end
      end
      tick(1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rb = 8'($urandom_range(0, 127));
            5, 6:          rb = 8'($urandom_range(8'h80, 8'hEF));
            7:             rb = 8'($urandom_range(8'hF0, 8'hF7));
            8:             rb = 8'($urandom_range(8'hF8, 8'hFF));
            default:       rb = ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hF7;
         endcase
         rr  = ($urandom_range(0, 199) == 0);
         rdv = ($urandom_range(0, 3) != 0);
         tick(rr, rdv, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
Sits directly downstream of each MIDI port's UART receiver and consumes its byte stream (rxdv/rxdata). Assembles raw bytes into complete MIDI messages, handling running status, interleaved realtime bytes and SysEx. The router reads whole messages from it instead of single bytes. No backpressure: every output is a registered one-cycle pulse.

Parameters:
FILTER_CLOCK, 1, when 1 drop 0xF8 timing clock (no output, no state change)
FILTER_SENSE, 1, when 1 drop 0xFE active sensing
ERR_CNT_W, 16, width of saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_dv  in  1  one-cycle strobe, input byte valid
in_data  in  8  received byte
msg_valid  out  1  one-cycle pulse, complete message on msg_*
msg_status  out  8  status byte (effective status, including running status)
msg_data1  out  7  first data byte, 0 if unused
msg_data2  out  7  second data byte, 0 if unused
msg_len  out  2  total message length in bytes: 1, 2 or 3
sx_valid  out  1  one-cycle pulse, SysEx byte on sx_data
sx_data  out  8  SysEx byte (F0, 7-bit data, F7)
sx_abort  out  1  one-cycle pulse, SysEx ended by a status byte other than F7
err_pulse  out  1  one-cycle pulse, stray data byte or truncated message
err_count  out  ERR_CNT_W  saturating count of err_pulse events

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all outputs 0, state IDLE, running status cleared. Reset wins over a same-cycle in_dv. Reset mid-message discards the partial message; nothing is emitted.
- Latency: outputs register exactly 1 cycle after the in_dv carrying the final byte. Outputs hold their values when no pulse is active; only the *_valid/abort/err flags pulse.
- States: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX. Registers: rs_status[7:0], d1[6:0].
- Channel status 0x80-0xEF: load rs_status. C0-DF need 1 data byte (len 2); all others need 2 (len 3). Go to WAIT_D1.
- WAIT_D1 + data byte: if len 2, emit and stay in WAIT_D1 (running status). Else latch d1 and go to WAIT_D2.
- WAIT_D2 + data byte: emit len 3. Return to WAIT_D1 for channel status, or to IDLE for F2.
- System common F1/F3 (len 2) and F2 (len 3): clear running status, then collect data as above. After emitting, go to IDLE.
- System common F6: emit len 1, go to IDLE. F4/F5: clear running status, go to IDLE, no output.
- Realtime 0xF8-0xFF: emit a len-1 message the next cycle unless filtered. State, rs_status and d1 are untouched, including inside SysEx and mid-message. F9/FD are emitted like other realtime bytes.
- F0: clear running status, emit sx F0, go to SYSEX.
- SYSEX: each data byte is emitted on sx. F7 is emitted on sx, then go to IDLE. Realtime passes as above.
- SYSEX + any other status byte: pulse sx_abort, then process that byte normally in the same cycle. Any message pulse it causes is simultaneous with sx_abort.
- Stray data byte in IDLE: drop it, pulse err_pulse. F7 outside SYSEX: drop it, pulse err_pulse.
- Non-realtime status byte arriving in WAIT_D2, or in WAIT_D1 before any data byte of a new (non-running) message: pulse err_pulse (truncated), then process the new status.
- Running-status WAIT_D1 interrupted by a new status byte: no error.
- err_count increments once per err_pulse and saturates at all-ones.
- msg_valid and sx_valid are never both 1 except for realtime inside SysEx, which uses msg_valid only, so they are never simultaneous.

Decomposition:
- Shared package midi_pkg holds:
  - status constants: ST_SYSEX=F0, ST_EOX=F7, ST_CLOCK=F8, ST_SENSE=FE, ST_TUNE=F6
  - function msg_len_of(status) returning 0/1/2/3
  - function is_realtime(byte)
- Sub-module: none required. The parser is one FSM plus a counter. The saturating error counter may be an instance of sat_counter if one already exists.

Test Plan:
- Bytes 90 3C 40, then 3E 50 (running status) -> two msg_valid pulses: {90,3C,40,len3} and {90,3E,50,len3}, each 1 cycle after its last byte.
- Bytes C5 07 08 -> {C5,07,0,len2} twice. Then F8 with FILTER_CLOCK=0 -> {F8,0,0,len1}. With FILTER_CLOCK=1 -> no pulse.
- Bytes 90 3C FA 40 -> FA emitted len1 immediately, then {90,3C,40,len3}. Running status survives.
- Bytes F0 7E 01 F8 F7 -> sx pulses F0,7E,01,F7; F8 on msg_valid between them (FILTER_CLOCK=0). Then F0 01 90 -> sx F0,01, then sx_abort with the 90 processed.
- Bytes 40 (after reset) -> err_pulse, err_count=1. Then 90 3C B0 -> err_pulse (truncated), err_count=2. Then 07 7F -> {B0,07,7F}. Force err_count to max, add a stray byte -> count stays at max.
- rst asserted between 90 and 3C -> no output. Subsequent 3C -> err_pulse (running status cleared).
